parking_gate_ctrl: RTL
======================

Name: parking_gate_ctrl

Overview:
- Front-end gate controller sitting directly upstream of the parking FSM and car counter.
- Conditions the raw active-low entry/exit push-buttons: synchroniser, debounce, falling-edge detect.
- Arbitrates simultaneous requests against parking_full/parking_empty and runs the barrier-gate open/close sequence.
- Emits single-cycle entry_req/exit_req pulses with a latched car_id for the downstream FSM.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=2).
- GATE_OPEN_CYCLES, 64, cycles the barrier stays open per accepted event (>=2).
- ID_W, 2, car identifier width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- entry_btn_n  in  1  raw entry button/sensor, active-low, asynchronous to clk.
- exit_btn_n  in  1  raw exit button/sensor, active-low, asynchronous to clk.
- car_id_in  in  ID_W  car identifier presented with the button; sampled at acceptance.
- parking_full  in  1  from car counter; blocks entry.
- parking_empty  in  1  from car counter; blocks exit.
- entry_req  out  1  one-cycle pulse: entry accepted.
- exit_req  out  1  one-cycle pulse: exit accepted.
- car_id_out  out  ID_W  car_id latched at acceptance; held until next acceptance.
- reject  out  1  one-cycle pulse: event refused (entry while full / exit while empty).
- gate_open  out  1  barrier drive, high while open.
- busy  out  1  high in any state other than IDLE.
- state  out  2  current FSM state encoding.

Behaviour:
- Decided: reset reset, asynchronous, active-high; clock clk. All flops clear on reset.
- Reset values:
  - Outputs: entry_req, exit_req, reject, gate_open, busy = 0; car_id_out = 0; state = IDLE.
  - Internals: sync flops and debounced levels = 1 (released); debounce counters = 0; timer = 0.
- Synchroniser: 2 flops per button.
- Debounce, per input:
  - Counter clears whenever the sync output equals the debounced level.
  - Otherwise the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the input still differs, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Event: registered 1->0 transition of the debounced level; one cycle wide. Release (0->1) generates nothing.
- Latency: a clean press held low produces entry_req/exit_req exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples it low.
- FSM states: IDLE=00, ENTRY_OPEN=01, EXIT_OPEN=10, CLOSING=11.
- IDLE, entry event:
  - parking_full=0 -> entry_req=1, car_id_out<=car_id_in, gate_open<=1, timer<=GATE_OPEN_CYCLES-1, go ENTRY_OPEN.
  - parking_full=1 -> reject=1, stay IDLE.
- IDLE, exit event:
  - parking_empty=0 -> exit_req=1, latch id, open gate, load timer, go EXIT_OPEN.
  - parking_empty=1 -> reject=1, stay IDLE.
- IDLE, simultaneous entry and exit events:
  - Entry wins if parking_full=0.
  - Otherwise exit is evaluated as above.
  - The losing event is dropped, with no reject unless it was itself blocked.
  - If both are blocked, a single reject pulse is issued.
- ENTRY_OPEN/EXIT_OPEN: timer decrements each cycle; at timer==0 -> gate_open<=0, go CLOSING.
- CLOSING: one cycle, then IDLE.
- Events arriving while busy=1 are discarded (no reject).
- Timer width: $clog2(GATE_OPEN_CYCLES); no wrap; decrement only while nonzero.
- Gate open duration: gate_open is high for exactly GATE_OPEN_CYCLES cycles.
- At most one of entry_req/exit_req/reject is high in any cycle.
- Reset mid-operation: gate closes immediately, state returns to IDLE, and the pending debounce is lost. A button held through reset deassertion yields one event once debounced.

Optional Feature:
- Macro: PARKING_GATE_EVENT_LATCH_EN.
- Defined:
  - A one-deep pending register captures the first event (type + car_id_in) that arrives while busy=1.
  - Later events are dropped.
  - The pending event is evaluated in IDLE on the cycle after CLOSING, with the normal full/empty rules.
  - Reset clears the pending register.
- Undefined: events while busy are discarded, as above.

Decomposition:
- Shared package parking_pkg:
  - FSM state encoding constants for IDLE/ENTRY_OPEN/EXIT_OPEN/CLOSING.
  - ID_W default.
  - An event-type enum (NONE/ENTRY/EXIT).
- Natural sub-module: btn_debounce (2-flop sync + counter + falling-edge pulse), instantiated twice with DEBOUNCE_CYCLES.

Test Plan:
- Clean entry press: entry_btn_n low for 40 cycles, car_id_in=2, full=0 (DEBOUNCE_CYCLES=16) -> entry_req pulse at edge 20, car_id_out=2, gate_open high 64 cycles, then CLOSING, then IDLE.
- Glitch rejection: entry_btn_n low 10 cycles then high -> no entry_req, no reject, state stays IDLE.
- Blocked events:
  - Entry press with parking_full=1 -> single reject pulse, gate_open stays 0.
  - Exit press with parking_empty=1 -> single reject pulse.
- Simultaneous press: both buttons low together, full=0, empty=0 -> entry_req only. Repeat with full=1 -> exit_req only, no reject.
- Busy drop/latch: exit press 10 cycles after an accepted entry.
  - Macro undefined -> no exit_req.
  - Macro defined -> exit_req one cycle after CLOSING.
- Reset mid-open: assert reset 20 cycles into ENTRY_OPEN -> gate_open=0, state=IDLE, all pulses 0 immediately. After release, normal entry works.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking gate front end: FSM state encoding,
// event types seen by the arbiter, and the default car-id width.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ENTRY_OPEN = 2'b01,
        ST_EXIT_OPEN  = 2'b10,
        ST_CLOSING    = 2'b11
    } gate_state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_ENTRY = 2'b01,
        EV_EXIT  = 2'b10
    } event_t;

    localparam int ID_W_DEFAULT = 2;

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw active-low button: two-flop synchroniser, a stability
// counter that only lets the level change after DEBOUNCE_CYCLES consecutive
// differing samples, and a registered one-cycle pulse on each press (1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic fall_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             deb_level;
    logic             deb_prev;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain; released level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive samples that disagree with the debounced level; any
    // agreeing sample restarts the count, so short glitches never toggle it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= 1'b1;
            cnt       <= '0;
        end else if (sync_2 == deb_level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb_level <= sync_2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered falling-edge detect on the debounced level; release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev   <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            deb_prev   <= deb_level;
            fall_pulse <= deb_prev & ~deb_level;
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier front end: debounces entry/exit buttons, arbitrates them
// against parking_full/parking_empty and runs the open/close sequence.
// Optional build macro PARKING_GATE_EVENT_LATCH_EN keeps the first event seen
// while busy and replays it once the gate is back in IDLE.
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  IDLE       | gate closed, waiting for an entry/exit event
//  ENTRY_OPEN | entry accepted, barrier open, timer running
//  EXIT_OPEN  | exit accepted, barrier open, timer running
//  CLOSING    | barrier just dropped, one cycle before IDLE
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int GATE_OPEN_CYCLES = 64,
    parameter int ID_W             = ID_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            entry_btn_n,
    input  logic            exit_btn_n,
    input  logic [ID_W-1:0] car_id_in,
    input  logic            parking_full,
    input  logic            parking_empty,
    output logic            entry_req,
    output logic            exit_req,
    output logic [ID_W-1:0] car_id_out,
    output logic            reject,
    output logic            gate_open,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int TMR_W = (GATE_OPEN_CYCLES > 2) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_OPEN_CYCLES - 1);

    logic entry_ev;
    logic exit_ev;

    gate_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic            gate_q, gate_d;
    logic            entry_q, entry_d;
    logic            exit_q, exit_d;
    logic            reject_q, reject_d;
    logic [ID_W-1:0] car_id_q, car_id_d;

    logic            eval_entry;
    logic            eval_exit;
    logic [ID_W-1:0] eval_id;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (entry_btn_n),
        .fall_pulse (entry_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (exit_btn_n),
        .fall_pulse (exit_ev)
    );

`ifdef PARKING_GATE_EVENT_LATCH_EN
    event_t          pend_type_q, pend_type_d;
    logic [ID_W-1:0] pend_id_q, pend_id_d;

    // Pick what IDLE evaluates: a held event takes precedence over fresh ones;
    // the first event seen while busy is captured, later ones are dropped.
    always_comb begin
        pend_type_d = pend_type_q;
        pend_id_d   = pend_id_q;
        eval_entry  = 1'b0;
        eval_exit   = 1'b0;
        eval_id     = car_id_in;
        if (state_q != ST_IDLE) begin
            if ((pend_type_q == EV_NONE) && (entry_ev || exit_ev)) begin
                pend_type_d = entry_ev ? EV_ENTRY : EV_EXIT;
                pend_id_d   = car_id_in;
            end
        end else if (pend_type_q != EV_NONE) begin
            eval_entry  = (pend_type_q == EV_ENTRY);
            eval_exit   = (pend_type_q == EV_EXIT);
            eval_id     = pend_id_q;
            pend_type_d = EV_NONE;
        end else begin
            eval_entry = entry_ev;
            eval_exit  = exit_ev;
        end
    end

    // One-deep pending event register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_type_q <= EV_NONE;
            pend_id_q   <= '0;
        end else begin
            pend_type_q <= pend_type_d;
            pend_id_q   <= pend_id_d;
        end
    end
`else
    // Events only matter in IDLE; anything arriving while busy is discarded.
    always_comb begin
        eval_entry = entry_ev && (state_q == ST_IDLE);
        eval_exit  = exit_ev && (state_q == ST_IDLE);
        eval_id    = car_id_in;
    end
`endif

    // Next state and registered outputs: entry beats exit unless blocked, and
    // a blocked request (or two blocked requests) gives a single reject.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        gate_d   = gate_q;
        entry_d  = 1'b0;
        exit_d   = 1'b0;
        reject_d = 1'b0;
        car_id_d = car_id_q;
        case (state_q)
            ST_IDLE: begin
                if (eval_entry && !parking_full) begin
                    entry_d  = 1'b1;
                    car_id_d = eval_id;
                    gate_d   = 1'b1;
                    timer_d  = TMR_LOAD;
                    state_d  = ST_ENTRY_OPEN;
                end else if (eval_exit && !parking_empty) begin
                    exit_d   = 1'b1;
                    car_id_d = eval_id;
                    gate_d   = 1'b1;
                    timer_d  = TMR_LOAD;
                    state_d  = ST_EXIT_OPEN;
                end else if (eval_entry || eval_exit) begin
                    reject_d = 1'b1;
                end
            end
            ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
                if (timer_q == '0) begin
                    gate_d  = 1'b0;
                    state_d = ST_CLOSING;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CLOSING: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timer and output registers; reset drops the gate immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            gate_q   <= 1'b0;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
            reject_q <= 1'b0;
            car_id_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gate_q   <= gate_d;
            entry_q  <= entry_d;
            exit_q   <= exit_d;
            reject_q <= reject_d;
            car_id_q <= car_id_d;
        end
    end

    assign entry_req  = entry_q;
    assign exit_req   = exit_q;
    assign reject     = reject_q;
    assign gate_open  = gate_q;
    assign car_id_out = car_id_q;
    assign state      = state_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
